// File: rtl/i2c_pkg.sv
// Shared types and default parameters for the I2C bus monitor.
package i2c_pkg;

  typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_e;

  localparam int I2C_FILT_LEN_DEF   = 3;
  localparam int I2C_TMO_CYCLES_DEF = 4096;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line glitch filter: the output follows the raw level only after the raw
// level has differed from it for FILT_LEN consecutive cycles. Edge pulses are
// registered with the output update so they line up with the new level.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = I2C_FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Count disagreeing cycles; toggle once the run is long enough.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (raw_i != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = raw_i;
        rise_d = raw_i;
        fall_d = ~raw_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Filter state; the idle bus level (high) is the reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: filters SCL/SDA, decodes START/STOP/repeated START and
// tracks bus busy state with an SCL-stuck-low timeout.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int FILT_LEN   = I2C_FILT_LEN_DEF,
  parameter int TMO_CYCLES = I2C_TMO_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic rstart_o,
  output logic stop_o,
  output logic busy_o,
  output logic tmo_o
);

  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TMO_CYCLES == 0) ? '0 : TW'(TMO_CYCLES - 1);

  logic sda_rise, sda_fall;
  logic scl_quiet, start_ev, stop_ev;

  bus_state_e    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (scl_i),
    .filt_o (scl_o),
    .rise_o (scl_rise_o),
    .fall_o (scl_fall_o)
  );

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (sda_i),
    .filt_o (sda_o),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // SDA moving while SCL is high and steady; a simultaneous SCL edge is ambiguous.
  assign scl_quiet = ~scl_rise_o & ~scl_fall_o;
  assign start_ev  = sda_fall & scl_quiet & scl_o;
  assign stop_ev   = sda_rise & scl_quiet & scl_o;

  // Bus FSM next state, timeout counter and event pulses.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    start_o   = start_ev;
    rstart_o  = 1'b0;
    stop_o    = stop_ev;
    tmo_o     = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        tmo_cnt_d = '0;
        if (start_ev) state_d = BUS_BUSY;
      end
      BUS_BUSY: begin
        if (start_ev) begin
          rstart_o  = 1'b1;
          tmo_cnt_d = '0;
        end else if (stop_ev) begin
          state_d   = BUS_IDLE;
          tmo_cnt_d = '0;
        end else if (scl_o || (TMO_CYCLES == 0)) begin
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_o     = 1'b1;
          state_d   = BUS_IDLE;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d   = BUS_IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BUS_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign busy_o = (state_q == BUS_BUSY);

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed testbench for i2c_bus_monitor (FILT_LEN=3, TMO_CYCLES=16 and 0).
module tb_i2c_bus_monitor;

  logic clk = 1'b0;
  logic rst_n, scl_i, sda_i;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o, busy_o, tmo_o;
  logic scl_o_n, sda_o_n, scl_rise_n, scl_fall_n, start_n, rstart_n, stop_n, busy_n, tmo_n;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  i2c_bus_monitor #(.FILT_LEN(3), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
    .scl_o(scl_o), .sda_o(sda_o), .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o),
    .start_o(start_o), .rstart_o(rstart_o), .stop_o(stop_o), .busy_o(busy_o), .tmo_o(tmo_o)
  );

  i2c_bus_monitor #(.FILT_LEN(3), .TMO_CYCLES(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
    .scl_o(scl_o_n), .sda_o(sda_o_n), .scl_rise_o(scl_rise_n), .scl_fall_o(scl_fall_n),
    .start_o(start_n), .rstart_o(rstart_n), .stop_o(stop_n), .busy_o(busy_n), .tmo_o(tmo_n)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    step(2);
    tests_run++;
    if ({scl_o, sda_o} !== 2'b11) begin
      tests_failed++; $display("FAIL reset_lines: got %b required 11", {scl_o, sda_o});
    end
    tests_run++;
    if ({scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o, busy_o, tmo_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 0000000",
               {scl_rise_o, scl_fall_o, start_o, rstart_o, stop_o, busy_o, tmo_o});
    end
    rst_n = 1'b1;
    step(2);
    $display("[TB] reset done");
  endtask

  task automatic test_glitch();
    scl_i = 1'b0;
    step(2);
    scl_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (scl_o !== 1'b1 || scl_fall_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch: got scl_o=%b fall=%b required 1 0", scl_o, scl_fall_o);
      end
    end
    $display("[TB] 2-cycle SCL glitch rejected");
  endtask

  task automatic test_scl_edges();
    scl_i = 1'b0;
    step(2);
    tests_run++;
    if (scl_o !== 1'b1) begin
      tests_failed++; $display("FAIL scl_early: got %b required 1", scl_o);
    end
    step();
    tests_run++;
    if (scl_o !== 1'b0 || scl_fall_o !== 1'b1) begin
      tests_failed++; $display("FAIL scl_fall: got scl_o=%b fall=%b required 0 1", scl_o, scl_fall_o);
    end
    step();
    tests_run++;
    if (scl_fall_o !== 1'b0) begin
      tests_failed++; $display("FAIL scl_fall_width: got %b required 0", scl_fall_o);
    end
    scl_i = 1'b1;
    step(3);
    tests_run++;
    if (scl_o !== 1'b1 || scl_rise_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL scl_rise: got scl_o=%b rise=%b busy=%b required 1 1 0", scl_o, scl_rise_o, busy_o);
    end
    step();
    $display("[TB] SCL fall/rise latency 3 cycles");
  endtask

  task automatic test_start_stop();
    sda_i = 1'b0;
    step(2);
    tests_run++;
    if (start_o !== 1'b0) begin
      tests_failed++; $display("FAIL start_early: got %b required 0", start_o);
    end
    step();
    tests_run++;
    if ({start_o, rstart_o, busy_o} !== 3'b100) begin
      tests_failed++; $display("FAIL start: got start/rstart/busy=%b required 100", {start_o, rstart_o, busy_o});
    end
    step();
    tests_run++;
    if ({start_o, busy_o} !== 2'b01) begin
      tests_failed++; $display("FAIL start_busy: got start/busy=%b required 01", {start_o, busy_o});
    end
    sda_i = 1'b1;
    step(3);
    tests_run++;
    if ({stop_o, busy_o} !== 2'b11) begin
      tests_failed++; $display("FAIL stop: got stop/busy=%b required 11", {stop_o, busy_o});
    end
    step();
    tests_run++;
    if ({stop_o, busy_o} !== 2'b00) begin
      tests_failed++; $display("FAIL stop_idle: got stop/busy=%b required 00", {stop_o, busy_o});
    end
    $display("[TB] START then STOP");
  endtask

  task automatic test_rstart();
    sda_i = 1'b0;
    step(4);
    scl_i = 1'b0; step(4);
    sda_i = 1'b1; step(4);
    tests_run++;
    if (stop_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++; $display("FAIL sda_rise_scl_low: got stop=%b busy=%b required 0 1", stop_o, busy_o);
    end
    scl_i = 1'b1; step(4);
    sda_i = 1'b0;
    step(3);
    tests_run++;
    if ({start_o, rstart_o, busy_o} !== 3'b111) begin
      tests_failed++; $display("FAIL rstart: got start/rstart/busy=%b required 111", {start_o, rstart_o, busy_o});
    end
    step();
    tests_run++;
    if ({start_o, rstart_o, busy_o, busy_n} !== 4'b0011) begin
      tests_failed++; $display("FAIL rstart_after: got start/rstart/busy/busy_nt=%b required 0011",
                               {start_o, rstart_o, busy_o, busy_n});
    end
    $display("[TB] repeated START in BUSY");
  endtask

  task automatic test_timeout();
    int early = 0;
    scl_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (tmo_o !== 1'b0 || busy_o !== 1'b1) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++; $display("FAIL tmo_early: got %0d bad cycles required 0", early);
    end
    step();
    tests_run++;
    if ({tmo_o, busy_o, tmo_n} !== 3'b110) begin
      tests_failed++; $display("FAIL tmo_fire: got tmo/busy/tmo_nt=%b required 110", {tmo_o, busy_o, tmo_n});
    end
    step();
    tests_run++;
    if ({tmo_o, busy_o, busy_n} !== 3'b001) begin
      tests_failed++; $display("FAIL tmo_after: got tmo/busy/busy_nt=%b required 001", {tmo_o, busy_o, busy_n});
    end
    step(30);
    tests_run++;
    if ({tmo_n, busy_n} !== 2'b01) begin
      tests_failed++; $display("FAIL tmo_disabled: got tmo_nt/busy_nt=%b required 01", {tmo_n, busy_n});
    end
    $display("[TB] SCL-low timeout after 16 cycles, disabled variant stays busy");
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({scl_o_n, sda_o_n, busy_n, scl_rise_n, scl_fall_n, start_n, rstart_n, stop_n, tmo_n} !== 9'b110000000) begin
      tests_failed++;
      $display("FAIL reset_mid: got %b required 110000000",
               {scl_o_n, sda_o_n, busy_n, scl_rise_n, scl_fall_n, start_n, rstart_n, stop_n, tmo_n});
    end
    scl_i = 1'b1; sda_i = 1'b1;
    step();
    rst_n = 1'b1;
    step(4);
    $display("[TB] reset mid-transfer");
  endtask

  task automatic test_simultaneous();
    scl_i = 1'b0; sda_i = 1'b0;
    step(3);
    tests_run++;
    if ({scl_fall_o, sda_o, start_o} !== 3'b100) begin
      tests_failed++; $display("FAIL simul_fall: got fall/sda/start=%b required 100", {scl_fall_o, sda_o, start_o});
    end
    step();
    scl_i = 1'b1; sda_i = 1'b1;
    step(3);
    tests_run++;
    if ({scl_rise_o, sda_o, stop_o, busy_o} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL simul_rise: got rise/sda/stop/busy=%b required 1100", {scl_rise_o, sda_o, stop_o, busy_o});
    end
    step();
    $display("[TB] simultaneous SCL/SDA toggles give no START/STOP");
  endtask

  task automatic test_stop_idle();
    scl_i = 1'b0; step(4);
    sda_i = 1'b0; step(4);
    scl_i = 1'b1; step(4);
    sda_i = 1'b1;
    step(3);
    tests_run++;
    if ({stop_o, busy_o, start_o} !== 3'b100) begin
      tests_failed++; $display("FAIL stop_in_idle: got stop/busy/start=%b required 100", {stop_o, busy_o, start_o});
    end
    step();
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL stop_in_idle_busy: got %b required 0", busy_o);
    end
    $display("[TB] STOP while idle");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_scl_edges();
    test_start_stop();
    test_rstart();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    test_stop_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
